// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and the master/slave bus benches.
// Holds the arbiter state encoding. The plain localparams are for code that
// wants raw codes, and the enum is for typed state registers.
package bus_arbiter_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWNED   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_OWNED   = OWNED,
    ST_RELEASE = RELEASE
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Ports:
//   eligible   in  N         : candidate masters (request and not masked)
//   last_grant in  clog2(N)  : most recent grantee; the search starts just above it
//   winner     out N         : one-hot winner, zero when nothing is eligible
//   win_idx    out clog2(N)  : index of the winner
//   valid      out 1         : some master is eligible
module rr_priority_picker #(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0]         eligible,
  input  logic [$clog2(NUM_MASTERS)-1:0] last_grant,
  output logic [NUM_MASTERS-1:0]         winner,
  output logic [$clog2(NUM_MASTERS)-1:0] win_idx,
  output logic                           valid
);

  localparam int ID_W = $clog2(NUM_MASTERS);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Walk last_grant+1, last_grant+2, ... wrapping modulo N. The first hit wins,
  // so the previous owner is always the lowest priority.
  always_comb begin
    winner   = '0;
    win_idx  = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand     = (int'(last_grant) + k) % NUM_MASTERS;
      cand_idx = ID_W'(cand);
      if (!valid && eligible[cand_idx]) begin
        valid            = 1'b1;
        win_idx          = cand_idx;
        winner[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial data bus.
// Grants one master at a time. It holds the grant through slave turnaround
// (slave_busy) and inserts a one-cycle RELEASE gap after every grant. A
// watchdog force-releases a grant that is held too long and masks that master
// until the master drops its request.
// Ports:
//   clk         in  1        : clock, rising edge
//   rstn        in  1        : asynchronous active-low reset
//   m_req       in  N        : per-master level request
//   slave_busy  in  1        : shared slave busy line
//   m_grant     out N        : registered one-hot grant
//   grant_id    out clog2(N) : index of the current or most recent grantee
//   bus_util    out 1        : high exactly while a grant is owned
//   timeout_err out 1        : one-cycle pulse during a watchdog release
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic                           slave_busy,
  output logic [NUM_MASTERS-1:0]         m_grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           bus_util,
  output logic                           timeout_err
);

  localparam int ID_W = $clog2(NUM_MASTERS);

  arb_state_e                state_q, state_d;
  logic [NUM_MASTERS-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]           grant_id_q, grant_id_d;
  logic [ID_W-1:0]           last_grant_q, last_grant_d;
  logic [NUM_MASTERS-1:0]    to_mask_q, to_mask_d;
  logic [TIMEOUT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                      terr_q, terr_d;

  logic [NUM_MASTERS-1:0]    eligible;
  logic [NUM_MASTERS-1:0]    pick_onehot;
  logic [ID_W-1:0]           pick_idx;
  logic                      pick_valid;
  logic                      rel_ok;
  logic                      wd_fire;

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(input logic [TIMEOUT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign eligible = m_req & ~to_mask_q;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .eligible  (eligible),
    .last_grant(last_grant_q),
    .winner    (pick_onehot),
    .win_idx   (pick_idx),
    .valid     (pick_valid)
  );

  // The grantee is finished only when it has dropped its request and the slave
  // has completed its turnaround.
  assign rel_ok  = !m_req[grant_id_q] && !slave_busy;
  assign wd_fire = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) && !rel_ok;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    terr_d       = 1'b0;
    // A master's timeout mask clears as soon as it stops requesting.
    to_mask_d    = to_mask_q & m_req;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_onehot;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          cnt_d        = '0;
          state_d      = ST_OWNED;
        end
      end
      ST_OWNED: begin
        cnt_d = sat_inc(cnt_q);
        // A normal release takes priority because wd_fire already excludes rel_ok.
        if (rel_ok) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (wd_fire) begin
          grant_d               = '0;
          terr_d                = 1'b1;
          to_mask_d[grant_id_q] = 1'b1;
          state_d               = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_MASTERS - 1);
      to_mask_q    <= '0;
      cnt_q        <= '0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      to_mask_q    <= to_mask_d;
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
    end
  end

  assign m_grant     = grant_q;
  assign grant_id    = grant_id_q;
  assign bus_util    = (state_q == ST_OWNED);
  assign timeout_err = terr_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared serial data bus between up to `NUM_MASTERS` bus masters. Grants one master at a time, drives the shared `bus_util` line that slaves watch to leave `WAIT_FOR_PEER`, and holds the grant across slave memory turnaround (`slave_busy`). Enforces a watchdog timeout so a hung master or slave cannot lock the bus. Sits at bus top level beside the master and slave instances.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters, 2..8.
- `TIMEOUT_CYCLES`, 255: maximum cycles a grant may be held in OWNED; 0 disables the watchdog.
- `TIMEOUT_WIDTH`, 8: counter width; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `m_req` in NUM_MASTERS: per-master request, level, held for the whole transaction.
- `slave_busy` in 1: shared slave busy line, read-only here; pulled-up/Z is treated as 0.
- `m_grant` out NUM_MASTERS: one-hot grant, registered.
- `grant_id` out $clog2(NUM_MASTERS): index of the current or most recent grantee.
- `bus_util` out 1: bus in use; high exactly while in OWNED.
- `timeout_err` out 1: one-cycle pulse on watchdog release.

## Operation
- Reset values: `m_grant`=0, `grant_id`=0, `bus_util`=0, `timeout_err`=0, state IDLE, `last_grant`=NUM_MASTERS-1 (master 0 is highest priority first), `to_mask`=0, counter 0.
- IDLE: eligible = `m_req & ~to_mask`. If nonzero, pick the first eligible index searching upward from `last_grant+1` modulo NUM_MASTERS; register the one-hot `m_grant`, set `grant_id`, `last_grant`, `bus_util`=1, clear the counter, go to OWNED. Otherwise stay.
- OWNED: counter increments each cycle, saturating. Release when the grantee's `m_req`=0 and `slave_busy`=0 in the same cycle: go to RELEASE. If the grantee drops `m_req` while `slave_busy`=1, hold the grant until `slave_busy` falls.
- Watchdog: if `TIMEOUT_CYCLES`≠0, the counter equals `TIMEOUT_CYCLES`, and the release condition is not met, go to RELEASE, pulse `timeout_err`, and set `to_mask[grantee]`. Normal release takes priority over timeout when both are true in the same cycle.
- RELEASE: `m_grant`=0 and `bus_util`=0 for exactly one turnaround cycle, then go to IDLE.
- `to_mask[i]` clears in any cycle where `m_req[i]`=0. A timed-out master must drop its request before it can win again.
- Requests from non-granted masters are ignored in OWNED and RELEASE. They are not latched; they are simply re-evaluated in IDLE.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). Masters and slaves see `bus_util` fall and return to idle.

## Timing
- Request at an IDLE edge t: `m_grant` and `bus_util` are high after edge t+1. Latency is 1 cycle.
- Release condition sampled at edge t: grant drops after t+1 (RELEASE), state is IDLE after t+2, and the earliest next grant is after t+3. Minimum bus gap is 2 cycles.
- A timeout fires after `TIMEOUT_CYCLES`+1 cycles of OWNED. `timeout_err` is high for the RELEASE cycle only.
- `m_grant` is always one-hot or zero. `bus_util` = |`m_grant`.

## Structure
- Package `bus_arbiter_pkg`: state encoding localparams (IDLE=2'd0, OWNED=2'd1, RELEASE=2'd2). The package is shared with slave/master top-level TBs.
- Sub-module `rr_priority_picker`: combinational. Inputs are the eligible vector and `last_grant`; outputs are the one-hot winner, its index, and a valid flag.
- The arbiter FSM, counter and mask live in `bus_arbiter`.

## Test plan
- Reset, then `m_req`=3'b001 → `m_grant`=001 and `bus_util`=1 one cycle later. Drop req with `slave_busy`=0 → grant 0 after 1 cycle; IDLE 1 cycle later.
- `m_req`=3'b111 held continuously, each owner releasing after 4 cycles → grant order 0,1,2,0 with a 2-cycle gap between grants.
- Master 1 drops req while `slave_busy`=1 for 10 cycles → grant held 10 cycles, released on the first cycle `slave_busy`=0.
- `TIMEOUT_CYCLES`=8, master 0 holds req forever → `timeout_err` pulse after 9 OWNED cycles. Master 0 is not regranted until it drops req once; master 2 requesting is granted next.
- Release and timeout coincide on the same cycle → `timeout_err` stays 0 and `to_mask` is unchanged.
- `rstn` pulled low mid-OWNED → `m_grant`=0, `bus_util`=0 asynchronously. After reset, master 0 wins a 3'b111 request.
